alu_issue_ctrl: RTL

Issue-side controller for the execute stage: accepts MIPS-style R-type instructions over a valid/ready handshake, encodes them into the 5-bit ALU operation code, and registers the result for writeback. It also sequences MULT/DIV as two multi-cycle ALU passes into HI/LO registers and serves MFHI/MFLO from them. It sits between instruction decode and the combinational ALU, whose A/B operands come directly from the register file.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_funct_decode.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage issue controller:
// ALU operation codes, R-type funct values, FSM state and decode kind.
package alu_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  localparam logic [4:0] ALU_SLL   = 5'b00000;
  localparam logic [4:0] ALU_ROL   = 5'b00001;
  localparam logic [4:0] ALU_SRL   = 5'b00010;
  localparam logic [4:0] ALU_ROR   = 5'b00011;
  localparam logic [4:0] ALU_SRA   = 5'b00110;
  localparam logic [4:0] ALU_MULLO = 5'b10000;
  localparam logic [4:0] ALU_DIV   = 5'b10001;
  localparam logic [4:0] ALU_MULHI = 5'b10010;
  localparam logic [4:0] ALU_REM   = 5'b10011;
  localparam logic [4:0] ALU_ADD   = 5'b10110;
  localparam logic [4:0] ALU_SUB   = 5'b10111;
  localparam logic [4:0] ALU_AND   = 5'b11000;
  localparam logic [4:0] ALU_OR    = 5'b11001;
  localparam logic [4:0] ALU_NOR   = 5'b11010;
  localparam logic [4:0] ALU_XOR   = 5'b11011;
  localparam logic [4:0] ALU_SLT   = 5'b11111;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ROL  = 6'h01;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ROR  = 6'h05;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ST_IDLE, ST_EXEC, ST_WB, ST_MD_LO, ST_MD_HI
  } state_t;

  typedef enum logic [2:0] {
    K_SINGLE, K_MD, K_MFHI, K_MFLO, K_ILLEGAL
  } kind_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type decode: funct/opcode to ALU op and instruction kind.
// For MULT/DIV the op returned is the LO pass; the HI pass is chosen later.
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [4:0] op,
  output kind_t      kind
);

  // Map the funct field; any non-R-type opcode is illegal with a zero op.
  always_comb begin
    op   = ALU_SLL;
    kind = K_ILLEGAL;
    if (opcode == OPC_RTYPE) begin
      kind = K_SINGLE;
      case (funct)
        FN_SLL:  op = ALU_SLL;
        FN_ROL:  op = ALU_ROL;
        FN_SRL:  op = ALU_SRL;
        FN_ROR:  op = ALU_ROR;
        FN_SRA:  op = ALU_SRA;
        FN_ADD:  op = ALU_ADD;
        FN_SUB:  op = ALU_SUB;
        FN_AND:  op = ALU_AND;
        FN_OR:   op = ALU_OR;
        FN_NOR:  op = ALU_NOR;
        FN_XOR:  op = ALU_XOR;
        FN_SLT:  op = ALU_SLT;
        FN_MULT: begin op = ALU_MULLO; kind = K_MD; end
        FN_DIV:  begin op = ALU_DIV;   kind = K_MD; end
        FN_MFHI: kind = K_MFHI;
        FN_MFLO: kind = K_MFLO;
        default: kind = K_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: handshakes R-type instructions in,
// drives a registered ALU op, registers single-op results for writeback
// and runs MULT/DIV as two held ALU passes into LO then HI.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MD_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_of,
  output logic             wb_valid,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_of,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             illegal
);

  localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  state_t           state, state_nxt;
  logic [4:0]       dec_op;
  kind_t            dec_kind;
  kind_t            ex_kind;
  logic             md_div;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             accept;

  alu_funct_decode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .op     (dec_op),
    .kind   (dec_kind)
  );

  assign accept   = in_valid & in_ready;
  assign cnt_last = (cnt == CNT_W'(MD_LAT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; WB accepts like IDLE so issue can overlap writeback.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_WB: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          case (dec_kind)
            K_SINGLE, K_MFHI, K_MFLO: state_nxt = ST_EXEC;
            K_MD:                     state_nxt = ST_MD_LO;
            default:                  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_EXEC:  state_nxt = ST_WB;
      ST_MD_LO: if (cnt_last) state_nxt = ST_MD_HI;
      ST_MD_HI: if (cnt_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded handshake and writeback strobe.
  always_comb begin
    in_ready = (state == ST_IDLE) || (state == ST_WB);
    wb_valid = (state == ST_WB);
  end

  // Registered ALU op: loaded on accept, swapped to the HI pass, cleared after use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op  <= ALU_SLL;
      ex_kind <= K_SINGLE;
      md_div  <= 1'b0;
    end else if (accept) begin
      alu_op  <= dec_op;
      ex_kind <= dec_kind;
      md_div  <= (dec_op == ALU_DIV);
    end else if (state == ST_EXEC) begin
      alu_op  <= ALU_SLL;
    end else if ((state == ST_MD_LO) && cnt_last) begin
      alu_op  <= md_div ? ALU_REM : ALU_MULHI;
    end else if ((state == ST_MD_HI) && cnt_last) begin
      alu_op  <= ALU_SLL;
    end
  end

  // Hold counter for the multicycle mul/div passes; restarts each pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if ((state == ST_MD_LO) || (state == ST_MD_HI))
      cnt <= cnt_last ? '0 : cnt + 1'b1;
    else
      cnt <= '0;
  end

  // Writeback capture at the end of EXEC; MFHI/MFLO bypass the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data <= '0;
      wb_of   <= 1'b0;
    end else if (state == ST_EXEC) begin
      case (ex_kind)
        K_MFHI:  begin wb_data <= hi; wb_of <= 1'b0; end
        K_MFLO:  begin wb_data <= lo; wb_of <= 1'b0; end
        default: begin wb_data <= alu_result; wb_of <= alu_of; end
      endcase
    end
  end

  // HI/LO capture on the last held cycle of each pass; divide-by-zero is not special.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo <= '0;
      hi <= '0;
    end else begin
      if ((state == ST_MD_LO) && cnt_last) lo <= alu_result;
      if ((state == ST_MD_HI) && cnt_last) hi <= alu_result;
    end
  end

  // One-cycle pulse for an accepted unsupported instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal <= 1'b0;
    else        illegal <= accept && (dec_kind == K_ILLEGAL);
  end

endmodule
